alu_operand_sequencer: RTL and testbench



---
 rtl/alu_operand_sequencer.sv | 134 +++++++++++++
 tb/tb_alu_operand_sequencer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
// Sequences operand A, operand B and the opcode from a shared switch bus into
// a combinational ALU using one load button. It then captures the ALU result
// and offers it downstream on a valid/ready handshake.
// Optional build macro: ALU_OPCODE_CHECK_EN. When defined, an illegal opcode
// is rejected in LOAD_OP and o_op_err is raised.
module alu_operand_sequencer #(
  parameter int NB_OP = 6,
  parameter int NB_AB = 4,
  parameter int NB_SW = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NB_SW-1:0] i_sw,
  input  logic             i_load,
  output logic [NB_AB-1:0] o_alu_a,
  output logic [NB_AB-1:0] o_alu_b,
  output logic [NB_OP-1:0] o_alu_op,
  input  logic [NB_AB-1:0] i_alu_result,
  output logic [NB_AB-1:0] o_result,
  output logic             o_result_valid,
  input  logic             i_result_ready,
  output logic [2:0]       o_state,
  output logic             o_op_err
);

  localparam logic [2:0] LOAD_A  = 3'd0;
  localparam logic [2:0] LOAD_B  = 3'd1;
  localparam logic [2:0] LOAD_OP = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] HOLD    = 3'd4;

  logic [2:0]       r_state;
  logic             r_s1, r_s2, r_s3;
  logic             w_load_pulse;
  logic [NB_AB-1:0] w_sw_ab;
  logic [NB_OP-1:0] w_sw_op;
  logic             w_unused_sw;

  assign w_sw_ab     = i_sw[NB_AB-1:0];
  assign w_sw_op     = i_sw[NB_OP-1:0];
  // Bits above the captured fields are deliberately ignored.
  assign w_unused_sw = ^i_sw;

  // Synchronize the asynchronous button and remember the previous level for edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_load;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // A single pulse per button press, however long the button is held.
  assign w_load_pulse = r_s2 & ~r_s3;

`ifdef ALU_OPCODE_CHECK_EN
  logic w_op_legal;
  logic r_op_err;

  // Legal opcodes are the eight operations the ALU implements.
  always_comb begin
    w_op_legal = 1'b0;
    case (w_sw_op)
      NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100),
      NB_OP'(6'b100101), NB_OP'(6'b100110), NB_OP'(6'b100111),
      NB_OP'(6'b000011), NB_OP'(6'b000010): w_op_legal = 1'b1;
      default:                               w_op_legal = 1'b0;
    endcase
  end

  assign o_op_err = r_op_err;
`else
  assign o_op_err = 1'b0;
`endif

  // Sequencer FSM: load A, B and the opcode, execute for one cycle, then hold the result until it is accepted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= LOAD_A;
      o_alu_a        <= '0;
      o_alu_b        <= '0;
      o_alu_op       <= '0;
      o_result       <= '0;
      o_result_valid <= 1'b0;
`ifdef ALU_OPCODE_CHECK_EN
      r_op_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        LOAD_A: if (w_load_pulse) begin
          o_alu_a <= w_sw_ab;
          r_state <= LOAD_B;
        end
        LOAD_B: if (w_load_pulse) begin
          o_alu_b <= w_sw_ab;
          r_state <= LOAD_OP;
        end
        LOAD_OP: if (w_load_pulse) begin
`ifdef ALU_OPCODE_CHECK_EN
          if (w_op_legal) begin
            o_alu_op <= w_sw_op;
            r_op_err <= 1'b0;
            r_state  <= EXEC;
          end else begin
            r_op_err <= 1'b1;
          end
`else
          o_alu_op <= w_sw_op;
          r_state  <= EXEC;
`endif
        end
        // The ALU inputs have been stable for a full cycle, so its result is settled here.
        EXEC: begin
          o_result       <= i_alu_result;
          o_result_valid <= 1'b1;
          r_state        <= HOLD;
        end
        HOLD: if (i_result_ready) begin
          o_result_valid <= 1'b0;
          r_state        <= LOAD_A;
        end
        default: r_state <= LOAD_A;
      endcase
    end
  end

  assign o_state = r_state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer, with a small behavioural ALU in the feedback path.
module tb_alu_operand_sequencer;
  localparam int NB_OP = 6, NB_AB = 4, NB_SW = 8;

  logic             clk = 1'b0, rst = 1'b1, load = 1'b0, ready = 1'b1;
  logic [NB_SW-1:0] sw = '0;
  logic [NB_AB-1:0] alu_a, alu_b, alu_res, result;
  logic [NB_OP-1:0] alu_op;
  logic             valid, op_err;
  logic [2:0]       state;
  int               n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  alu_operand_sequencer #(.NB_OP(NB_OP), .NB_AB(NB_AB), .NB_SW(NB_SW)) dut (
    .i_clk(clk), .i_rst(rst), .i_sw(sw), .i_load(load),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
    .i_alu_result(alu_res), .o_result(result), .o_result_valid(valid),
    .i_result_ready(ready), .o_state(state), .o_op_err(op_err)
  );

  // Reference ALU; unknown opcodes return 0.
  always_comb begin
    alu_res = '0;
    case (alu_op)
      6'b100000: alu_res = alu_a + alu_b;
      6'b100010: alu_res = alu_a - alu_b;
      6'b100100: alu_res = alu_a & alu_b;
      6'b100101: alu_res = alu_a | alu_b;
      6'b100110: alu_res = alu_a ^ alu_b;
      6'b100111: alu_res = ~(alu_a | alu_b);
      6'b000011: alu_res = $signed(alu_a) >>> alu_b;
      6'b000010: alu_res = alu_a >> alu_b;
      default:   alu_res = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press the button and return just after the capturing edge (k+2).
  task automatic press(input logic [NB_SW-1:0] v);
    sw   = v;
    load = 1'b1;
    tick(3);
    load = 1'b0;
  endtask

  // Press the button, then wait long enough for the synchronizer to see the release.
  task automatic press_rel(input logic [NB_SW-1:0] v);
    press(v);
    tick(2);
  endtask

  initial begin
    tick(2);
    chk("rst_a", alu_a, 0);   chk("rst_b", alu_b, 0);  chk("rst_op", alu_op, 0);
    chk("rst_res", result, 0); chk("rst_vld", valid, 0); chk("rst_st", state, 0);
    chk("rst_err", op_err, 0);
    rst = 1'b0;
    tick(1);

    // 3 + 2 = 5, with ready already high, so valid lasts one cycle.
    press(8'h03);     chk("t1_a", alu_a, 4'h3); chk("t1_st1", state, 1); tick(2);
    press(8'h02);     chk("t1_b", alu_b, 4'h2); chk("t1_st2", state, 2); tick(2);
    press(8'h20);     chk("t1_st3", state, 3); chk("t1_vld0", valid, 0);
    tick(1);          chk("t1_res", result, 4'h5); chk("t1_vld1", valid, 1); chk("t1_st4", state, 4);
    tick(1);          chk("t1_vld2", valid, 0); chk("t1_st0", state, 0); chk("t1_res2", result, 4'h5);
    tick(2);

    // 2 - 5 = -3; the operands are kept after returning to LOAD_A.
    press_rel(8'h02); press_rel(8'h05); press(8'h22);
    tick(1);          chk("t2_res", result, 4'hD); chk("t2_vld", valid, 1);
    tick(1);          chk("t2_st", state, 0);
    chk("t2_a", alu_a, 4'h2); chk("t2_b", alu_b, 4'h5); chk("t2_op", alu_op, 6'h22);
    tick(2);

    // Hold with ready low; two extra presses are dropped.
    ready = 1'b0;
    press_rel(8'h01); press_rel(8'h01); press(8'h20);
    tick(1);          chk("t3_vld", valid, 1); chk("t3_res", result, 4'h2); chk("t3_st", state, 4);
    press_rel(8'hFF); press_rel(8'hFF);
    chk("t3_vld_h", valid, 1); chk("t3_res_h", result, 4'h2); chk("t3_st_h", state, 4);
    chk("t3_a", alu_a, 4'h1); chk("t3_b", alu_b, 4'h1); chk("t3_op", alu_op, 6'h20);
    ready = 1'b1;
    tick(1);          chk("t3_vld_d", valid, 0); chk("t3_st0", state, 0); chk("t3_res_k", result, 4'h2);
    chk("t3_a_k", alu_a, 4'h1);

    // A long press in LOAD_A captures once, at k+2.
    sw = 8'h07; load = 1'b1;
    tick(2);          chk("t4_a_k1", alu_a, 4'h1); chk("t4_st_k1", state, 0);
    tick(1);          chk("t4_a_k2", alu_a, 4'h7); chk("t4_st_k2", state, 1);
    tick(17);         chk("t4_a_hold", alu_a, 4'h7); chk("t4_st_hold", state, 1);
    load = 1'b0;
    tick(2);

    // Reset asserted mid-cycle while in LOAD_OP.
    press_rel(8'h03); chk("t5_pre", state, 2);
    #2 rst = 1'b1;
    #1;
    chk("t5_a", alu_a, 0);   chk("t5_b", alu_b, 0); chk("t5_op", alu_op, 0);
    chk("t5_res", result, 0); chk("t5_vld", valid, 0); chk("t5_st", state, 0);
    chk("t5_err", op_err, 0);
    #1 rst = 1'b0;
    tick(2);
    // 4 + (-3) = 1; upper switch bits are ignored.
    press_rel(8'hF4); press_rel(8'hFD); press(8'h20);
    tick(1);          chk("t5_res2", result, 4'h1); chk("t5_vld2", valid, 1);
    tick(1);          chk("t5_st2", state, 0);
    tick(2);

    // Illegal opcode 111111.
    press_rel(8'h03); press_rel(8'h02); press(8'h3F);
`ifdef ALU_OPCODE_CHECK_EN
    chk("t6_err", op_err, 1); chk("t6_st", state, 2); chk("t6_op", alu_op, 6'h20);
    tick(2);
    press(8'h24);     chk("t6_err_clr", op_err, 0); chk("t6_st3", state, 3);
    tick(1);          chk("t6_res", result, 4'h2); chk("t6_vld", valid, 1);
`else
    chk("t6_st3", state, 3); chk("t6_op", alu_op, 6'h3F); chk("t6_err", op_err, 0);
    tick(1);          chk("t6_res", result, 4'h0); chk("t6_vld", valid, 1);
`endif
    tick(1);          chk("t6_st0", state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
